// File: rtl/instruction_fetch.sv
// Instruction fetch stage: a request/hold FSM around a single instruction register.
// It also computes the next PC and counts the instructions that decode consumes.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        decode_ready,
   input  logic        branch,
   input  logic        zero,
   input  logic        j,
   input  logic        jal,
   input  logic        jr,
   input  logic [31:0] rs_data,
   output logic        addr_error,
   output logic [31:0] fetch_count,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      ERROR = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        fetch_done;
   logic        consume;
   logic        jr_misaligned;
   logic [31:0] branch_off;
   logic [31:0] next_pc;

   // Handshakes: memory data is taken only when imem_req && imem_ready in the same
   // cycle; decode takes instr only when instr_valid && decode_ready in the same cycle.
   assign fetch_done    = (state == FETCH) && imem_ready;
   assign consume       = (state == HOLD) && decode_ready;
   assign jr_misaligned = jr && (rs_data[1:0] != 2'b00);

   assign imem_addr = pc_out;
   assign pc_plus4  = pc_out + 32'd4;
   assign opcode    = instr[31:26];
   assign state_dbg = state;

   assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (jr) begin
         next_pc = rs_data;
      end else if (j || jal) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (branch && zero) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         FETCH: begin
            imem_req = ~reset;
            if (imem_ready) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (decode_ready) begin
               state_next = jr_misaligned ? ERROR : FETCH;
            end
         end
         ERROR: begin
            state_next = ERROR;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out      <= RESET_PC;
         instr       <= 32'h0000_0000;
         addr_error  <= 1'b0;
         fetch_count <= 32'h0000_0000;
      end else begin
         if (fetch_done) begin
            instr <= imem_data;
         end
         if (consume) begin
            fetch_count <= fetch_count + 32'd1;
            // A misaligned jr target is never loaded; the PC freezes on the faulting jr.
            if (jr_misaligned) begin
               addr_error <= 1'b1;
            end else begin
               pc_out <= next_pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch/consume rules.
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        decode_ready;
   logic        branch;
   logic        zero;
   logic        j;
   logic        jal;
   logic        jr;
   logic [31:0] rs_data;
   logic        addr_error;
   logic [31:0] fetch_count;
   logic [1:0]  state_dbg;

   int n_vec;
   int n_err;

   // model state
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_cnt;
   bit          m_hold;
   bit          m_err;

   instruction_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_data(imem_data), .instr(instr), .opcode(opcode),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
      .decode_ready(decode_ready), .branch(branch), .zero(zero), .j(j), .jal(jal),
      .jr(jr), .rs_data(rs_data), .addr_error(addr_error), .fetch_count(fetch_count),
      .state_dbg(state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_target();
      logic [31:0]        seq;
      logic signed [31:0] off;
      seq = m_pc + 32'd4;
      off = $signed(m_instr[15:0]);
      if (jr) return rs_data;
      if (j || jal) return (seq & 32'hF000_0000) + ({6'd0, m_instr[25:0]} * 32'd4);
      if (branch && zero) return seq + off * 4;
      return seq;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic mstep();
      if (reset) begin
         m_pc = RESET_PC; m_instr = 0; m_cnt = 0; m_hold = 0; m_err = 0;
         return;
      end
      if (m_err) return;
      if (!m_hold) begin
         if (imem_ready) begin
            m_instr = imem_data;
            m_hold  = 1;
         end
      end else if (decode_ready) begin
         m_cnt  = m_cnt + 1;
         m_hold = 0;
         if (jr && (rs_data % 4 != 0)) m_err = 1;
         else m_pc = model_target();
      end
   endtask

   // driver tasks
   task automatic clear_inputs();
      imem_ready = 0; imem_data = 0; decode_ready = 0;
      branch = 0; zero = 0; j = 0; jal = 0; jr = 0; rs_data = 0;
   endtask

   task automatic do_fetch(input logic [31:0] data);
      imem_ready = 1; imem_data = data; decode_ready = 0;
      mstep(); tick();
      imem_ready = 0; imem_data = $urandom;
   endtask

   task automatic do_consume(input logic br, input logic z, input logic jj,
                             input logic jl, input logic jrr, input logic [31:0] rs);
      decode_ready = 1; branch = br; zero = z; j = jj; jal = jl; jr = jrr; rs_data = rs;
      mstep(); tick();
      clear_inputs();
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1;
      mstep(); tick();
      reset = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1; imem_ready = 1; imem_data = 32'hDEAD_BEEF; decode_ready = 1;
      #1;
      n_vec++;
      if (imem_req !== 1'b0) begin
         n_err++; $display("FAIL reset_req: imem_req=%b expected 0", imem_req);
      end
      mstep(); tick();
      mstep(); tick();
      n_vec++;
      if (pc_out !== RESET_PC || instr !== 32'h0 || instr_valid !== 1'b0 ||
          fetch_count !== 32'h0 || addr_error !== 1'b0 || imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: pc=%h instr=%h valid=%b cnt=%0d err=%b req=%b expected %h/0/0/0/0/0",
                  pc_out, instr, instr_valid, fetch_count, addr_error, imem_req, RESET_PC);
      end
      clear_inputs();
      reset = 0;
      #1;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC || pc_plus4 !== RESET_PC + 4) begin
         n_err++;
         $display("FAIL reset_release: req=%b addr=%h plus4=%h expected 1/%h/%h",
                  imem_req, imem_addr, pc_plus4, RESET_PC, RESET_PC + 4);
      end
   endtask

   task automatic test_sequential();
      imem_ready = 1; decode_ready = 1;
      for (int i = 0; i < 6; i++) begin
         imem_data = $urandom;
         mstep(); tick();
         n_vec++;
         if (pc_out !== 32'(4 * ((i + 1) / 2)) || instr_valid !== ((i % 2) == 0)) begin
            n_err++;
            $display("FAIL seq_step%0d: pc=%h valid=%b expected %h/%b", i, pc_out,
                     instr_valid, 4 * ((i + 1) / 2), (i % 2) == 0);
         end
      end
      n_vec++;
      if (fetch_count !== 32'd3) begin
         n_err++; $display("FAIL seq_count: count=%0d expected 3", fetch_count);
      end
      clear_inputs();
   endtask

   task automatic test_stall();
      do_fetch($urandom);
      do_consume(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         imem_ready = 0; imem_data = $urandom;
         mstep(); tick();
         n_vec++;
         if (imem_addr !== 32'h10 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_%0d: addr=%h req=%b valid=%b expected 00000010/1/0",
                     i, imem_addr, imem_req, instr_valid);
         end
      end
      do_fetch(32'h8C22_0004);
      n_vec++;
      if (instr_valid !== 1'b1 || instr !== 32'h8C22_0004) begin
         n_err++;
         $display("FAIL stall_release: valid=%b instr=%h expected 1/8c220004", instr_valid, instr);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) begin
         decode_ready = 0; imem_ready = 1; imem_data = $urandom;
         branch = 1; zero = 1; j = $urandom_range(0, 1); jr = 1; rs_data = $urandom;
         mstep(); tick();
         n_vec++;
         if (instr !== 32'h8C22_0004 || opcode !== 6'b100011 || pc_out !== 32'h10 ||
             instr_valid !== 1'b1 || fetch_count !== m_cnt) begin
            n_err++;
            $display("FAIL backpressure_%0d: instr=%h op=%b pc=%h valid=%b cnt=%0d expected 8c220004/100011/00000010/1/%0d",
                     i, instr, opcode, pc_out, instr_valid, fetch_count, m_cnt);
         end
      end
      clear_inputs();
      do_consume(0, 0, 0, 0, 0, 0);
      n_vec++;
      if (pc_out !== 32'h14) begin
         n_err++; $display("FAIL backpressure_release: pc=%h expected 00000014", pc_out);
      end
   endtask

   task automatic test_branch();
      for (int i = 0; i < 3; i++) begin
         do_fetch($urandom);
         do_consume(0, 0, 0, 0, 0, 0);
      end
      do_fetch(32'h1000_FFFE);
      do_consume(1, 1, 0, 0, 0, 0);
      n_vec++;
      if (pc_out !== 32'h1C) begin
         n_err++; $display("FAIL branch_taken: pc=%h expected 0000001c", pc_out);
      end
      do_fetch($urandom);
      do_consume(0, 0, 0, 0, 0, 0);
      do_fetch(32'h1000_FFFE);
      do_consume(1, 0, 0, 0, 0, 0);
      n_vec++;
      if (pc_out !== 32'h24) begin
         n_err++; $display("FAIL branch_untaken: pc=%h expected 00000024", pc_out);
      end
   endtask

   task automatic test_jumps();
      do_fetch(32'h0800_0010);
      do_consume(0, 0, 1, 0, 0, 0);
      n_vec++;
      if (pc_out !== 32'h40) begin
         n_err++; $display("FAIL jump_to_40: pc=%h expected 00000040", pc_out);
      end
      do_fetch(32'h0800_0100);
      do_consume(0, 0, 1, 0, 0, 0);
      n_vec++;
      if (pc_out !== 32'h400) begin
         n_err++; $display("FAIL jump_j: pc=%h expected 00000400", pc_out);
      end
      do_fetch(32'h0C00_0200);
      do_consume(0, 0, 0, 1, 0, 0);
      n_vec++;
      if (pc_out !== 32'h800) begin
         n_err++; $display("FAIL jump_jal: pc=%h expected 00000800", pc_out);
      end
      do_fetch(32'h0800_0100);
      do_consume(1, 1, 1, 0, 1, 32'h1234);
      n_vec++;
      if (pc_out !== 32'h1234) begin
         n_err++; $display("FAIL jump_jr: pc=%h expected 00001234", pc_out);
      end
      do_fetch($urandom);
      do_consume(0, 0, 0, 0, 1, 32'h1236);
      n_vec++;
      if (addr_error !== 1'b1 || pc_out !== 32'h1234 || fetch_count !== m_cnt) begin
         n_err++;
         $display("FAIL jr_misaligned: err=%b pc=%h cnt=%0d expected 1/00001234/%0d",
                  addr_error, pc_out, fetch_count, m_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         imem_ready = 1; decode_ready = 1; imem_data = $urandom;
         mstep(); tick();
         n_vec++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b0 || addr_error !== 1'b1 ||
             pc_out !== 32'h1234) begin
            n_err++;
            $display("FAIL error_sticky_%0d: req=%b valid=%b err=%b pc=%h expected 0/0/1/00001234",
                     i, imem_req, instr_valid, addr_error, pc_out);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_fetch();
      apply_reset();
      do_fetch($urandom);
      do_consume(0, 0, 0, 0, 0, 0);
      do_fetch($urandom);
      do_consume(0, 0, 0, 0, 0, 0);
      reset = 1; imem_ready = 1; imem_data = 32'hCAFE_F00D;
      mstep(); tick();
      n_vec++;
      if (instr !== 32'h0 || instr_valid !== 1'b0 || pc_out !== RESET_PC || fetch_count !== 32'h0) begin
         n_err++;
         $display("FAIL reset_mid_fetch: instr=%h valid=%b pc=%h cnt=%0d expected 0/0/%h/0",
                  instr, instr_valid, pc_out, fetch_count, RESET_PC);
      end
      clear_inputs(); reset = 0;
      do_fetch(32'h0800_0100);
      reset = 1; decode_ready = 1; jr = 1; rs_data = 32'h1236;
      mstep(); tick();
      n_vec++;
      if (pc_out !== RESET_PC || fetch_count !== 32'h0 || addr_error !== 1'b0 || instr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_consume: pc=%h cnt=%0d err=%b valid=%b expected %h/0/0/0",
                  pc_out, fetch_count, addr_error, instr_valid, RESET_PC);
      end
      clear_inputs(); reset = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 39) == 0);
         imem_ready   = ($urandom_range(0, 2) != 0);
         imem_data    = $urandom;
         decode_ready = $urandom_range(0, 1);
         branch       = $urandom_range(0, 1);
         zero         = $urandom_range(0, 1);
         j            = ($urandom_range(0, 3) == 0);
         jal          = ($urandom_range(0, 3) == 0);
         jr           = ($urandom_range(0, 3) == 0);
         rs_data      = $urandom;
         if ($urandom_range(0, 7) != 0) rs_data[1:0] = 2'b00;
         #1;
         n_vec++;
         if (imem_req !== (!reset && !m_hold && !m_err)) begin
            n_err++;
            $display("FAIL rand_req_%0d: req=%b expected %b", i, imem_req, !reset && !m_hold && !m_err);
         end
         mstep(); tick();
         n_vec++;
         if (pc_out !== m_pc || imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4 ||
             instr !== m_instr || opcode !== m_instr[31:26] || instr_valid !== m_hold ||
             fetch_count !== m_cnt || addr_error !== m_err) begin
            n_err++;
            $display("FAIL rand_state_%0d: pc=%h instr=%h valid=%b cnt=%0d err=%b expected %h/%h/%b/%0d/%b",
                     i, pc_out, instr, instr_valid, fetch_count, addr_error,
                     m_pc, m_instr, m_hold, m_cnt, m_err);
         end
      end
      clear_inputs();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_pc = RESET_PC; m_instr = 0; m_cnt = 0; m_hold = 0; m_err = 0;
      clear_inputs();
      reset = 1;
      test_reset();
      test_sequential();
      test_stall();
      test_backpressure();
      test_branch();
      test_jumps();
      test_reset_mid_fetch();
      apply_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the fetch address loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL be the word-aligned fetch address, equal to pc_out.
REQ-006 imem_ready  input  1  SHALL mean imem_data is valid this cycle.
REQ-007 imem_data  input  32  SHALL be the instruction word returned by memory.
REQ-008 instr  output  32  SHALL be the registered instruction handed to decode.
REQ-009 opcode  output  6  SHALL equal instr[31:26] and drive the control unit's opcode input.
REQ-010 pc_out  output  32  SHALL be the address of the current fetch or held instruction.
REQ-011 pc_plus4  output  32  SHALL equal pc_out + 4 (mod 2^32); it serves as the jal link value.
REQ-012 instr_valid  output  1  SHALL mean instr holds a valid instruction.
REQ-013 decode_ready  input  1  SHALL mean downstream consumes instr this cycle.
REQ-014 branch, zero, j, jal, jr  input  1 each  SHALL be the control/ALU redirect signals for the held instruction.
REQ-015 rs_data  input  32  SHALL be the jr target register value.
REQ-016 addr_error  output  1  SHALL be a sticky flag indicating a misaligned jr target.
REQ-017 fetch_count  output  32  SHALL count consumed instructions.

Function
REQ-018 The FSM SHALL have three states: FETCH, HOLD and ERROR.
REQ-019 In FETCH: imem_req=1 and instr_valid=0.
REQ-020 In HOLD: imem_req=0 and instr_valid=1.
REQ-021 In ERROR: imem_req=0 and instr_valid=0.
REQ-022 FETCH SHALL stay in FETCH while imem_ready=0, with imem_addr held stable.
REQ-023 On imem_ready=1 in FETCH: instr<=imem_data and the state SHALL go to HOLD, so instr_valid rises the next cycle (1-cycle latency).
REQ-024 imem_data SHALL be ignored unless the state is FETCH and imem_ready=1.
REQ-025 In HOLD with decode_ready=0: instr and pc_out SHALL remain unchanged; redirect inputs are ignored.
REQ-026 In HOLD with decode_ready=1 (consume): pc_out<=next_pc and fetch_count<=fetch_count+1 (wraps 32'hFFFFFFFF->0).
REQ-027 After a consume the state SHALL go to FETCH, giving a minimum of 2 cycles per instruction.
REQ-028 next_pc SHALL be selected by fixed priority:
- jr: rs_data;
- else j|jal: {pc_plus4[31:28], instr[25:0], 2'b00};
- else branch&zero: pc_plus4 + (sign-extend(instr[15:0]) << 2), mod 2^32;
- else pc_plus4.
REQ-029 If a consume has jr=1 and rs_data[1:0]!=0: addr_error<=1, pc_out unchanged, fetch_count still increments, state goes to ERROR.
REQ-030 ERROR SHALL be left only by reset.
REQ-031 Branch with zero=0 SHALL be treated as sequential.
REQ-032 Simultaneous j and jr SHALL resolve to jr per priority.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL load: pc_out=RESET_PC, instr=0, instr_valid=0, addr_error=0, fetch_count=0, state=FETCH.
REQ-034 reset SHALL override all other inputs, including an in-flight imem_ready or a consume in the same cycle; returned data is discarded.
REQ-035 While reset=1, imem_req SHALL be 0.
REQ-036 imem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-037 Sequential fetch: after reset, imem_ready=1, decode_ready=1, all redirects 0 -> pc_out sequence 0,4,8; instr_valid high every second cycle; fetch_count=3 after 3 consumes.
REQ-038 Memory stall: imem_ready=0 for 3 cycles at pc 0x10 -> imem_addr holds 0x10 and imem_req holds 1; instr_valid rises 1 cycle after imem_ready=1.
REQ-039 Decode backpressure: decode_ready=0 for 4 cycles with instr=0x8C220004 -> instr, opcode=6'b100011 and pc_out remain stable; redirect inputs are ignored.
REQ-040 Taken branch: pc_out=0x20, instr imm=16'hFFFE, branch=1, zero=1, consume -> next pc_out=0x1C.
REQ-041 Untaken branch: same stimulus with zero=0 -> next pc_out=0x24.
REQ-042 Jumps: j at pc 0x40 with instr[25:0]=26'h0000100 -> next pc_out=0x400. jr with rs_data=0x1234 -> next pc_out=0x1234. jr with rs_data=0x1236 -> addr_error=1, ERROR state, imem_req=0 until reset.
REQ-043 Reset mid-fetch: reset=1 in the same cycle as imem_ready=1 -> instr=0, instr_valid=0, pc_out=RESET_PC, fetch_count=0.
